robot_motion_sequencer: RTL and testbench
=========================================

Name: robot_motion_sequencer

Overview:
- Sits between the wall-following controller FSM (Mealy or Moore variant) and the motor drivers.
- Takes one move request per divided-clock tick: forward from `f_req`, rotate from `r_req`.
- Holds the matching motor line for a fixed number of ticks, then hands control back to the FSM.
- Counts consecutive rotations and parks the robot if it is spinning in place.

Parameters:
- CLK_DIV, 7, system clocks per tick (≥2); matches the team's clk_freq divider.
- FWD_TICKS, 2, ticks that `motor_fwd` is held per forward command (≥1).
- ROT_TICKS, 3, ticks that `motor_rot` is held per rotate command (≥1).
- STUCK_LIMIT, 4, consecutive rotations that trigger STUCK (≥1).

Ports:
- clk  in  1  system clock; all flops on rising edge.
- rst  in  1  asynchronous, active-high reset.
- f_req  in  1  forward request from the controller FSM.
- r_req  in  1  rotate request from the controller FSM.
- clear_stuck  in  1  operator release from STUCK.
- tick  out  1  one-cycle pulse every CLK_DIV clocks; the FSM advances on it.
- cmd_ready  out  1  high in IDLE; the FSM may present a request.
- motor_fwd  out  1  drive forward.
- motor_rot  out  1  rotate in place.
- busy  out  1  high in FWD or ROT.
- stuck  out  1  high in STUCK.

Behaviour:
- Reset:
  - All outputs 0; state IDLE.
  - Divider, duration and rotation counters all 0.
  - Async assert drops the motors the same cycle, including mid-move.
- Tick generation:
  - Divider counts 0..CLK_DIV-1 and wraps.
  - `tick`=1 in the cycle where count==CLK_DIV-1.
  - First tick after reset release occurs at the CLK_DIV-th clock.
- States: IDLE, FWD, ROT, STUCK. All outputs are registered, decoded from state.
- IDLE:
  - On an edge with `tick` & (`f_req` | `r_req`), the command is accepted.
  - Both requests high: rotation wins (turn before advancing).
  - No request: remain in IDLE.
  - Requests are ignored on non-tick cycles.
- FWD:
  - `motor_fwd`=1 from the cycle after acceptance.
  - Duration counter increments on each tick; at the FWD_TICKS-th tick, go to IDLE.
  - `motor_fwd` therefore stays high for exactly FWD_TICKS·CLK_DIV cycles.
  - Rotation counter clears on completion.
- ROT:
  - Same timing rule with ROT_TICKS and `motor_rot`.
  - On completion the rotation counter increments, saturating at STUCK_LIMIT.
  - If the new value == STUCK_LIMIT, go to STUCK; else go to IDLE.
- Command spacing: the completing tick is consumed. The next acceptance is at the following tick, giving at least one idle tick between moves.
- STUCK:
  - Motors 0, `stuck`=1, `cmd_ready`=0.
  - When `clear_stuck`=1 on any cycle (not tick-aligned), go to IDLE next cycle and clear the rotation counter.
  - `clear_stuck` outside STUCK is ignored.
- Invariant: `motor_fwd` & `motor_rot` are never both 1.
- Request changes during FWD/ROT have no effect.
- Width rules: counter widths are $clog2 of their maximum value, minimum 1 bit. No overflow is possible.

Optional Feature:
- Macro: SEQ_STUCK_DETECT_EN
- Defined: rotation counter and STUCK state behave as specified above.
- Undefined:
  - No rotation counter.
  - ROT always returns to IDLE.
  - `stuck` is tied to 0 and `clear_stuck` is unused.

Decomposition:
- Package robot_pkg holds:
  - state encoding localparams (IDLE=2'd0, FWD=2'd1, ROT=2'd2, STUCK=2'd3);
  - default timing constants.
- Sub-module robot_tick_gen:
  - parameter CLK_DIV; ports clk, rst, tick.
  - Reused by the Mealy and Moore controllers in place of their local dividers.

Test Plan:
- Reset release, `f_req`=1 held, defaults → `tick` at clock 7; `motor_fwd` high clocks 8–21 (14 cycles); `cmd_ready` low throughout.
- `f_req`=`r_req`=1 at a tick → `motor_rot` high for 21 cycles; `motor_fwd` stays 0.
- `r_req`=1 for 4 consecutive commands (macro defined) → `stuck`=1 the cycle after the 4th rotation ends; motors 0; `clear_stuck` pulse → IDLE next cycle, `cmd_ready`=1.
- Sequence r,r,r,f,r,r,r → `stuck` never asserts (forward clears the count).
- `rst` asserted mid-ROT (cycle 10 of 21) → `motor_rot`=0 that cycle; after release the first tick lands at clock 7 again.
- Macro undefined, 6 consecutive rotations → `stuck` stays 0; all 6 rotations complete.

Source files
------------

// File: rtl/robot_pkg.sv
// ============================================================================
// Module : robot_pkg
// Brief  : State encodings and default timing for the robot motion sequencer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package robot_pkg;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FWD   = 2'd1;
  localparam logic [1:0] ROT   = 2'd2;
  localparam logic [1:0] STUCK = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = IDLE,
    ST_FWD   = FWD,
    ST_ROT   = ROT,
    ST_STUCK = STUCK
  } seq_state_t;

  localparam int DEF_CLK_DIV     = 7;
  localparam int DEF_FWD_TICKS   = 2;
  localparam int DEF_ROT_TICKS   = 3;
  localparam int DEF_STUCK_LIMIT = 4;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/robot_tick_gen.sv
// ============================================================================
// Module : robot_tick_gen
// Brief  : Free-running divider; registered one-cycle tick every CLK_DIV clocks.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module robot_tick_gen
  import robot_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CNT_W = max_int(1, $clog2(CLK_DIV));
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;

  always_comb begin
    cnt_nxt = (cnt == CNT_LAST) ? '0 : cnt + CNT_W'(1);
  end

  // tick is registered off the next count so it lines up with cnt==CLK_DIV-1
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      cnt  <= cnt_nxt;
      tick <= (cnt_nxt == CNT_LAST);
    end
  end

endmodule

`default_nettype wire

// File: rtl/robot_motion_sequencer.sv
// ============================================================================
// Module : robot_motion_sequencer
// Brief  : Times forward/rotate motor commands per tick and parks on spinning.
//          Macro SEQ_STUCK_DETECT_EN enables the rotation counter and STUCK.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module robot_motion_sequencer
  import robot_pkg::*;
#(
  parameter int CLK_DIV     = DEF_CLK_DIV,
  parameter int FWD_TICKS   = DEF_FWD_TICKS,
  parameter int ROT_TICKS   = DEF_ROT_TICKS,
  parameter int STUCK_LIMIT = DEF_STUCK_LIMIT
) (
  input  logic clk,
  input  logic rst,
  input  logic f_req,
  input  logic r_req,
  input  logic clear_stuck,
  output logic tick,
  output logic cmd_ready,
  output logic motor_fwd,
  output logic motor_rot,
  output logic busy,
  output logic stuck
);

  localparam int DUR_MAX = max_int(FWD_TICKS, ROT_TICKS);
  localparam int DUR_W   = max_int(1, $clog2(DUR_MAX));
  localparam logic [DUR_W-1:0] FWD_LAST = DUR_W'(FWD_TICKS - 1);
  localparam logic [DUR_W-1:0] ROT_LAST = DUR_W'(ROT_TICKS - 1);

  seq_state_t       state;
  seq_state_t       state_nxt;
  logic [DUR_W-1:0] dur;
  logic [DUR_W-1:0] dur_nxt;

  robot_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

`ifdef SEQ_STUCK_DETECT_EN
  localparam int ROT_W = max_int(1, $clog2(STUCK_LIMIT + 1));
  localparam logic [ROT_W-1:0] ROT_LIMIT = ROT_W'(STUCK_LIMIT);

  logic [ROT_W-1:0] rot_cnt;
  logic [ROT_W-1:0] rot_cnt_nxt;
  logic [ROT_W-1:0] rot_inc;

  // Saturating increment: the counter never exceeds STUCK_LIMIT
  assign rot_inc = (rot_cnt == ROT_LIMIT) ? rot_cnt : rot_cnt + ROT_W'(1);
`else
  logic unused_clear_stuck;
  assign unused_clear_stuck = clear_stuck;
`endif

  always_comb begin
    state_nxt = state;
    dur_nxt   = dur;
`ifdef SEQ_STUCK_DETECT_EN
    rot_cnt_nxt = rot_cnt;
`endif
    case (state)
      ST_IDLE: begin
        // Rotation wins when both requests arrive together
        if (tick && (f_req || r_req)) begin
          state_nxt = r_req ? ST_ROT : ST_FWD;
          dur_nxt   = '0;
        end
      end
      ST_FWD: begin
        if (tick) begin
          if (dur == FWD_LAST) begin
            state_nxt = ST_IDLE;
            dur_nxt   = '0;
`ifdef SEQ_STUCK_DETECT_EN
            rot_cnt_nxt = '0;
`endif
          end else begin
            dur_nxt = dur + DUR_W'(1);
          end
        end
      end
      ST_ROT: begin
        if (tick) begin
          if (dur == ROT_LAST) begin
            dur_nxt = '0;
`ifdef SEQ_STUCK_DETECT_EN
            rot_cnt_nxt = rot_inc;
            state_nxt   = (rot_inc == ROT_LIMIT) ? ST_STUCK : ST_IDLE;
`else
            state_nxt = ST_IDLE;
`endif
          end else begin
            dur_nxt = dur + DUR_W'(1);
          end
        end
      end
      ST_STUCK: begin
`ifdef SEQ_STUCK_DETECT_EN
        if (clear_stuck) begin
          state_nxt   = ST_IDLE;
          rot_cnt_nxt = '0;
        end
`else
        state_nxt = ST_IDLE;
`endif
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they match the state flop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      dur       <= '0;
      cmd_ready <= 1'b0;
      motor_fwd <= 1'b0;
      motor_rot <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      dur       <= dur_nxt;
      cmd_ready <= (state_nxt == ST_IDLE);
      motor_fwd <= (state_nxt == ST_FWD);
      motor_rot <= (state_nxt == ST_ROT);
      busy      <= (state_nxt == ST_FWD) || (state_nxt == ST_ROT);
    end
  end

`ifdef SEQ_STUCK_DETECT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rot_cnt <= '0;
      stuck   <= 1'b0;
    end else begin
      rot_cnt <= rot_cnt_nxt;
      stuck   <= (state_nxt == ST_STUCK);
    end
  end
`else
  assign stuck = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_robot_motion_sequencer.sv
// ============================================================================
// Module : tb_robot_motion_sequencer
// Brief  : Directed self-checking bench for robot_motion_sequencer (defaults).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_robot_motion_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic f_req = 1'b0;
  logic r_req = 1'b0;
  logic clear_stuck = 1'b0;
  logic tick, cmd_ready, motor_fwd, motor_rot, busy, stuck;

  int n_checks = 0;
  int n_fail   = 0;

  robot_motion_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .f_req       (f_req),
    .r_req       (r_req),
    .clear_stuck (clear_stuck),
    .tick        (tick),
    .cmd_ready   (cmd_ready),
    .motor_fwd   (motor_fwd),
    .motor_rot   (motor_rot),
    .busy        (busy),
    .stuck       (stuck)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_tick();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (tick) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) check_val("tick_timeout", 0, 1);
  endtask

  // Present one request at a tick, then count motor-active cycles until idle
  task automatic do_move(input logic f, input logic r,
                         output int nf, output int nr, output int both);
    wait_tick();
    f_req = f;
    r_req = r;
    step();
    f_req = 1'b0;
    r_req = 1'b0;
    nf = 0; nr = 0; both = 0;
    for (int i = 0; i < 60; i++) begin
      if (!motor_fwd && !motor_rot) break;
      nf += int'(motor_fwd);
      nr += int'(motor_rot);
      both += int'(motor_fwd & motor_rot);
      step();
    end
  endtask

  initial begin
    int first_fwd, fwd_len, bad, tick_at, nf, nr, both, stuck_seen, sum_f, sum_r;

    repeat (3) step();
    check_val("rst_tick", tick, 0);
    check_val("rst_cmd_ready", cmd_ready, 0);
    check_val("rst_motor_fwd", motor_fwd, 0);
    check_val("rst_motor_rot", motor_rot, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_stuck", stuck, 0);

    // Forward with f_req held from reset release
    @(negedge clk);
    rst = 1'b0;
    f_req = 1'b1;
    first_fwd = -1; fwd_len = 0; bad = 0; tick_at = -1;
    for (int n = 1; n <= 22; n++) begin
      step();
      if (n == 1) check_val("idle_cmd_ready", cmd_ready, 1);
      if (tick && tick_at < 0) tick_at = n;
      if (motor_fwd) begin
        if (first_fwd < 0) first_fwd = n;
        fwd_len++;
        if (cmd_ready || !busy || motor_rot) bad++;
      end
    end
    check_val("first_tick", tick_at, 6);
    check_val("fwd_start", first_fwd, 7);
    check_val("fwd_len", fwd_len, 14);
    check_val("fwd_flags", bad, 0);
    check_val("fwd_done", motor_fwd, 0);
    check_val("nontick_ignored", cmd_ready, 1);
    f_req = 1'b0;

    // Both requests: rotation wins
    do_move(1'b1, 1'b1, nf, nr, both);
    check_val("both_rot_len", nr, 21);
    check_val("both_fwd_len", nf, 0);
    check_val("both_overlap", both, 0);

    do_move(1'b1, 1'b0, nf, nr, both);
    check_val("fwd2_len", nf, 14);
    check_val("fwd2_rot_len", nr, 0);

`ifdef SEQ_STUCK_DETECT_EN
    for (int k = 0; k < 4; k++) begin
      do_move(1'b0, 1'b1, nf, nr, both);
      check_val($sformatf("spin%0d_len", k), nr, 21);
    end
    check_val("stuck_set", stuck, 1);
    check_val("stuck_fwd", motor_fwd, 0);
    check_val("stuck_rot", motor_rot, 0);
    check_val("stuck_ready", cmd_ready, 0);
    check_val("stuck_busy", busy, 0);
    r_req = 1'b1;
    repeat (10) step();
    r_req = 1'b0;
    check_val("stuck_hold", stuck, 1);
    check_val("stuck_no_rot", motor_rot, 0);
    clear_stuck = 1'b1;
    step();
    clear_stuck = 1'b0;
    check_val("clear_stuck", stuck, 0);
    check_val("clear_ready", cmd_ready, 1);

    // r,r,r,f,r,r,r: the forward move resets the spin count
    stuck_seen = 0; sum_f = 0; sum_r = 0;
    for (int k = 0; k < 7; k++) begin
      do_move(k == 3, k != 3, nf, nr, both);
      sum_f += nf; sum_r += nr;
      stuck_seen += int'(stuck);
    end
    check_val("mix_stuck", stuck_seen, 0);
    check_val("mix_rot_total", sum_r, 126);
    check_val("mix_fwd_total", sum_f, 14);
`else
    stuck_seen = 0; sum_r = 0;
    for (int k = 0; k < 6; k++) begin
      do_move(1'b0, 1'b1, nf, nr, both);
      sum_r += nr;
      stuck_seen += int'(stuck);
    end
    check_val("spin6_stuck", stuck_seen, 0);
    check_val("spin6_rot_total", sum_r, 126);
    check_val("spin6_ready", cmd_ready, 1);
`endif

    // Asynchronous reset in the 10th cycle of a rotation
    wait_tick();
    r_req = 1'b1;
    step();
    r_req = 1'b0;
    repeat (9) step();
    check_val("midrot_active", motor_rot, 1);
    #2 rst = 1'b1;
    #1;
    check_val("async_rot_drop", motor_rot, 0);
    check_val("async_busy_drop", busy, 0);
    repeat (2) step();
    @(negedge clk);
    rst = 1'b0;
    tick_at = -1;
    for (int n = 1; n <= 10; n++) begin
      step();
      if (tick && tick_at < 0) tick_at = n;
    end
    check_val("retick", tick_at, 6);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
